unified_mem_arbiter: RTL
========================

Name: unified_mem_arbiter

Overview:
- Shares one single-port distributed RAM (sync write, async read on spo) between the instruction-fetch port and the data load/store port.
- Translates each port's byte address to a 16-bit word index using its own base, and grants at most one access per cycle.
- Data access has priority; a bounded-streak rule guarantees fetch progress.
- Read data is registered, giving a fixed one-cycle response latency.

Parameters:
PC_INITIAL, 32'hbfc00000, base byte address of the fetch window
ADDRESS_INITIAL, 32'h00000000, base byte address of the data window
STREAK_MAX, 4, max consecutive data grants while a fetch is pending (1..15)

Ports:
clk  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
i_req  in  1  fetch request; addr valid while high
i_addr  in  32  fetch byte address
i_gnt  out  1  combinational; fetch accepted this cycle when i_req & i_gnt
i_rvalid  out  1  response valid, exactly one cycle after an accepted fetch
i_rdata  out  32  fetched word, valid with i_rvalid
i_err  out  1  accepted fetch was out of window, valid with i_rvalid
d_req  in  1  data request
d_we  in  1  1 = word store, 0 = load
d_addr  in  32  data byte address
d_wdata  in  32  store data
d_gnt  out  1  combinational; data accepted when d_req & d_gnt
d_rvalid  out  1  response valid one cycle after an accepted data access
d_rdata  out  32  load data (for stores: word value before the write)
d_err  out  1  out-of-window access, valid with d_rvalid
ram_a  out  16  RAM word index
ram_we  out  1  RAM write enable
ram_d  out  32  RAM write data
ram_spo  in  32  RAM async read data

Behaviour:
- Reset (resetn=0, async): i_rvalid=d_rvalid=0, i_rdata=d_rdata=0, i_err=d_err=0, streak=0. i_gnt/d_gnt follow the grant rule unconditionally. ram_we=0 while in reset.
- Offset = addr - base (32-bit wrap). Word index = offset[17:2]. In window iff offset[31:18]==0. offset[1:0] is ignored; no alignment error is raised.
- Grant rule (combinational):
  - Only d_req: data granted.
  - Only i_req: fetch granted.
  - Both requesting: fetch granted iff streak==STREAK_MAX; otherwise data granted.
  - Never both granted in the same cycle.
- Streak counter (4 bits):
  - Data granted while i_req=1: streak+1, saturating at STREAK_MAX.
  - Fetch granted, or i_req=0: streak=0.
- RAM drive:
  - ram_a = index of the granted port; 0 if none granted.
  - ram_we = d_gnt & d_req & d_we & in-window.
  - ram_d = d_wdata.
  - Out-of-window accesses never assert ram_we.
- Response (registered at the edge that ends the grant cycle):
  - Granted port: rvalid=1; rdata=ram_spo (0 if out of window); err=!in_window.
  - Non-granted port: rvalid=0; rdata holds its last value.
- Store response: d_rdata is the pre-write word, because spo is sampled before the write edge.
- Back-to-back: a port may be granted every cycle. Responses stay in order, one per accepted request.
- Requester contract: i_addr, d_addr, d_we and d_wdata must be stable while req is high and not granted. A requester may drop req without penalty.
- Reset mid-operation: any pending response is discarded (rvalid forced 0); no RAM write occurs while resetn=0.

Test Plan:
- Reset: resetn=0 with d_req=1, d_we=1 -> ram_we=0; all rvalid/err=0. Release -> first data grant in that cycle.
- Fetch: i_addr=32'hbfc00008, RAM word 2 = 32'h24020001 -> i_gnt=1, ram_a=2 same cycle; next cycle i_rvalid=1, i_rdata=32'h24020001, i_err=0.
- Store then load: store d_addr=32'h10, d_wdata=32'hdeadbeef -> ram_a=4, ram_we=1, d_rvalid next cycle; following load of 32'h10 -> d_rdata=32'hdeadbeef.
- Contention, STREAK_MAX=4: i_req and d_req held high for 10 cycles -> grant sequence D,D,D,D,I,D,D,D,D,I, with rvalids following one cycle later in the same order.
- Out of window: i_addr=32'h00000000 -> i_err=1, i_rdata=0. d_we=1 at d_addr=32'h00040000 -> ram_we stays 0, d_err=1.
- Reset mid-access: assert resetn=0 in the grant cycle of a load -> no d_rvalid pulse after reset releases.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one async-read RAM between fetch and data ports.
// Data wins contention; a bounded data streak lets fetch through.
module unified_mem_arbiter #(
  parameter logic [31:0] PC_INITIAL      = 32'hbfc00000,
  parameter logic [31:0] ADDRESS_INITIAL = 32'h00000000,
  parameter int unsigned STREAK_MAX      = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_gnt,
  output logic        i_rvalid,
  output logic [31:0] i_rdata,
  output logic        i_err,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        d_err,
  output logic [15:0] ram_a,
  output logic        ram_we,
  output logic [31:0] ram_d,
  input  logic [31:0] ram_spo
);

  localparam logic [3:0] SMAX = 4'(STREAK_MAX);

  logic [31:0] i_off;
  logic [31:0] d_off;
  logic        i_in;
  logic        d_in;
  logic [15:0] i_idx;
  logic [15:0] d_idx;
  logic [3:0]  streak;
  logic [3:0]  streak_nxt;
  logic        fetch_turn;
  logic        unused_ok;

  assign i_off = i_addr - PC_INITIAL;
  assign d_off = d_addr - ADDRESS_INITIAL;
  assign i_in  = (i_off[31:18] == 14'd0);
  assign d_in  = (d_off[31:18] == 14'd0);
  assign i_idx = i_off[17:2];
  assign d_idx = d_off[17:2];

  // byte lane bits carry no meaning for word accesses
  assign unused_ok = ^{i_off[1:0], d_off[1:0]};

  assign fetch_turn = (streak == SMAX);
  assign i_gnt = i_req & (~d_req | fetch_turn);
  assign d_gnt = d_req & ~i_gnt;

  // RAM port follows whichever side won this cycle
  always_comb begin
    ram_a = 16'd0;
    if (d_gnt) ram_a = d_idx;
    else if (i_gnt) ram_a = i_idx;
  end

  assign ram_we = resetn & d_gnt & d_we & d_in;
  assign ram_d  = d_wdata;

  // count data wins while fetch waits, saturating
  always_comb begin
    streak_nxt = 4'd0;
    if (d_gnt & i_req) begin
      if (streak >= SMAX) streak_nxt = SMAX;
      else streak_nxt = streak + 4'd1;
    end
  end

  // streak register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) streak <= 4'd0;
    else streak <= streak_nxt;
  end

  // fetch response, one cycle after grant
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      i_rvalid <= 1'b0;
      i_rdata  <= 32'd0;
      i_err    <= 1'b0;
    end else begin
      i_rvalid <= i_gnt;
      if (i_gnt) begin
        i_rdata <= i_in ? ram_spo : 32'd0;
        i_err   <= ~i_in;
      end
    end
  end

  // data response; stores return the pre-write word
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      d_rvalid <= 1'b0;
      d_rdata  <= 32'd0;
      d_err    <= 1'b0;
    end else begin
      d_rvalid <= d_gnt;
      if (d_gnt) begin
        d_rdata <= d_in ? ram_spo : 32'd0;
        d_err   <= ~d_in;
      end
    end
  end

endmodule
